// File: rtl/mem_tx_streamer_pkg.sv
// Shared types for the data-memory transmit path: sequencer states, default
// bus widths, and the helper that picks one byte out of a memory word.
package mem_tx_streamer_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      SEND,
      WAIT_HI,
      WAIT_LO,
      FINISH
   } state_t;

   // Byte 0 is the low byte, which goes out on the wire first.
   function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic idx);
      return idx ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/mem_tx_streamer_tx_handshake.sv
// Hands one byte at a time to the UART with a start/busy handshake. A missing
// busy rise is flagged in err after BUSY_TO cycles and the byte is let go.
module mem_tx_streamer_tx_handshake
   import mem_tx_streamer_pkg::*;
#(
   parameter int BUSY_TO = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] byte_dat,
   input  logic       byte_vld,
   output logic       byte_ack,
   input  logic       err_clr,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic       err
);

   localparam int TO_W = $clog2(BUSY_TO + 1);

   state_t            state, next_state;
   logic [TO_W-1:0]   to_cnt;
   logic              timeout;

   assign timeout = (to_cnt == TO_W'(BUSY_TO - 1));

   always_comb begin
      next_state = state;
      byte_ack   = 1'b0;
      tx_start   = 1'b0;
      case (state)
         IDLE:    if (byte_vld) next_state = SEND;
         SEND: begin
            tx_start   = 1'b1;
            next_state = WAIT_HI;
         end
         WAIT_HI: if (tx_busy || timeout) next_state = WAIT_LO;
         WAIT_LO: begin
            // A back-to-back byte offered with the ack skips the idle cycle.
            if (!tx_busy) begin
               byte_ack   = 1'b1;
               next_state = byte_vld ? SEND : IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         to_cnt  <= '0;
         tx_data <= 8'h00;
         err     <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state == SEND) tx_data <= byte_dat;
         if (state == SEND)
            to_cnt <= '0;
         else if (state == WAIT_HI)
            to_cnt <= to_cnt + 1'b1;
         if (err_clr)
            err <= 1'b0;
         else if (state == WAIT_HI && !tx_busy && timeout)
            err <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_tx_streamer.sv
// Streams a contiguous range of data-memory words out through the UART, one
// read per word, bytes low-first; the byte handshake lives in the sub-module.
module mem_tx_streamer
   import mem_tx_streamer_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int BYTES_PER_WORD = 2,
   parameter int MEM_LAT        = 1,
   parameter int BUSY_TO        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_sent,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy
);

   state_t              state, next_state;
   logic [ADDR_W-1:0]   cur_addr, addr_hold;
   logic [ADDR_W:0]     len;
   logic [DATA_W-1:0]   word;
   logic                byte_idx;
   logic [1:0]          lat_cnt;
   logic                lat_last, more_bytes;
   logic [7:0]          byte_dat;
   logic                byte_vld, byte_ack, err_clr;

   assign lat_last   = (lat_cnt == 2'(MEM_LAT - 1));
   assign more_bytes = (BYTES_PER_WORD == 2) && !byte_idx;
   assign err_clr    = (state == IDLE) && start;
   assign mem_read   = (state == RD_REQ);
   assign mem_addr   = (state == RD_REQ) ? cur_addr : addr_hold;

   always_comb begin
      next_state = state;
      byte_vld   = 1'b0;
      byte_dat   = 8'h00;
      case (state)
         IDLE:    if (start) next_state = (length == '0) ? FINISH : RD_REQ;
         RD_REQ:  next_state = RD_WAIT;
         RD_WAIT: begin
            // First byte comes straight off the read bus so SEND follows the last wait cycle.
            if (lat_last) begin
               byte_vld   = 1'b1;
               byte_dat   = byte_sel(16'(mem_rdata), 1'b0);
               next_state = SEND;
            end
         end
         SEND: begin
            if (byte_ack) begin
               if (more_bytes) begin
                  byte_vld = 1'b1;
                  byte_dat = byte_sel(16'(word), 1'b1);
               end else begin
                  next_state = ((words_sent + 1'b1) == len) ? FINISH : RD_REQ;
               end
            end
         end
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_addr   <= '0;
         addr_hold  <= '0;
         len        <= '0;
         word       <= '0;
         byte_idx   <= 1'b0;
         lat_cnt    <= '0;
         words_sent <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state <= next_state;
         done  <= (state == FINISH);
         case (state)
            IDLE: begin
               if (start) begin
                  cur_addr   <= base_addr;
                  len        <= length;
                  words_sent <= '0;
                  busy       <= 1'b1;
               end
            end
            RD_REQ: begin
               addr_hold <= cur_addr;
               lat_cnt   <= '0;
            end
            RD_WAIT: begin
               lat_cnt <= lat_cnt + 1'b1;
               if (lat_last) begin
                  word     <= mem_rdata;
                  byte_idx <= 1'b0;
               end
            end
            SEND: begin
               if (byte_ack) begin
                  if (more_bytes) begin
                     byte_idx <= 1'b1;
                  end else begin
                     words_sent <= words_sent + 1'b1;
                     cur_addr   <= cur_addr + 1'b1;
                  end
               end
            end
            FINISH:  busy <= 1'b0;
            default: ;
         endcase
      end
   end

   mem_tx_streamer_tx_handshake #(.BUSY_TO(BUSY_TO)) u_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .byte_dat (byte_dat),
      .byte_vld (byte_vld),
      .byte_ack (byte_ack),
      .err_clr  (err_clr),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .err      (err)
   );

endmodule

// File: tb/tb_mem_tx_streamer.sv
// Directed bench for mem_tx_streamer with a synchronous memory model and a
// UART model that holds tx_busy for a programmable number of cycles.
module tb_mem_tx_streamer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] base_addr;
   logic [16:0] length;
   logic        busy, done, err;
   logic [16:0] words_sent;
   logic        mem_read;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;

   always #5 clk = ~clk;

   mem_tx_streamer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .words_sent (words_sent),
      .mem_read   (mem_read),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy)
   );

   logic [15:0] mem [0:65535];
   int          busy_len;
   int          busy_cnt;
   logic [7:0]  tx_log[$];
   logic [15:0] addr_log[$];
   int          done_cnt;
   int          n_checks = 0;
   int          n_fail   = 0;

   // One-cycle synchronous read.
   always @(posedge clk) begin
      if (mem_read) mem_rdata <= mem[mem_addr];
   end

   // Transmitter: busy for busy_len cycles after each tx_start (0 = never busy).
   always @(posedge clk) begin
      if (!rst_n) begin
         tx_busy  <= 1'b0;
         busy_cnt <= 0;
      end else if (tx_start && busy_len > 0) begin
         tx_busy  <= 1'b1;
         busy_cnt <= busy_len;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         tx_busy  <= 1'b0;
         busy_cnt <= 0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_start) tx_log.push_back(tx_data);
         if (mem_read) addr_log.push_back(mem_addr);
         if (done)     done_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      tx_log.delete();
      addr_log.delete();
      done_cnt = 0;
   endtask

   task automatic do_start(input logic [15:0] b, input logic [16:0] l);
      @(negedge clk);
      start     = 1'b1;
      base_addr = b;
      length    = l;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (done === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ctl"}, {busy, done, err, mem_read, tx_start}, 5'b0);
      check({tag, "_addr"}, mem_addr, 16'h0000);
      check({tag, "_txd"}, tx_data, 8'h00);
      check({tag, "_words"}, words_sent, 17'd0);
   endtask

   typedef struct {
      logic [15:0] base;
      logic [16:0] len;
      int          blen;
      logic [16:0] exp_words;
      logic        exp_err;
      int          exp_nbytes;
      logic [7:0]  exp_first;
      logic [7:0]  exp_last;
   } vec_t;

   vec_t tbl[6];

   task automatic run_vec(input vec_t v);
      logic        ok;
      logic [15:0] a, d;
      clear_logs();
      busy_len = v.blen;
      do_start(v.base, v.len);
      wait_done(2000, ok);
      check("done_seen", ok, 1'b1);
      check("words_sent", words_sent, v.exp_words);
      check("err", err, v.exp_err);
      check("busy_at_done", busy, 1'b0);
      check("nbytes", tx_log.size(), v.exp_nbytes);
      check("nreads", addr_log.size(), v.exp_words);
      if (tx_log.size() == v.exp_nbytes && v.exp_nbytes > 0) begin
         check("first_byte", tx_log[0], v.exp_first);
         check("last_byte", tx_log[v.exp_nbytes-1], v.exp_last);
         for (int w = 0; w < int'(v.len); w++) begin
            a = v.base + w[15:0];
            d = mem[a];
            if (addr_log.size() > w) check("rd_addr", addr_log[w], a);
            check("byte_lo", tx_log[2*w], d[7:0]);
            check("byte_hi", tx_log[2*w+1], d[15:8]);
         end
      end
      repeat (3) @(negedge clk);
      check("done_pulses", done_cnt, 1);
   endtask

   initial begin
      logic ok;
      int   k, k_tx;
      for (int i = 0; i < 65536; i++) mem[i] = ~16'(i);
      mem[16'h0010] = 16'hA55A;

      //             base      len     blen words err nb first  last
      tbl[0] = '{16'h0010, 17'd1, 5, 17'd1, 1'b0, 2, 8'h5A, 8'hA5};
      tbl[1] = '{16'hFFFF, 17'd3, 5, 17'd3, 1'b0, 6, 8'h00, 8'hFF};
      tbl[2] = '{16'h0100, 17'd2, 1, 17'd2, 1'b0, 4, 8'hFF, 8'hFE};
      tbl[3] = '{16'h0020, 17'd1, 0, 17'd1, 1'b1, 2, 8'hDF, 8'hFF};
      tbl[4] = '{16'h1234, 17'd0, 5, 17'd0, 1'b0, 0, 8'h00, 8'h00};
      tbl[5] = '{16'h0030, 17'd1, 3, 17'd1, 1'b0, 2, 8'hCF, 8'hFF};

      rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; busy_len = 5;
      done_cnt = 0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Start-to-first-tx_start latency and the single read strobe.
      clear_logs();
      busy_len = 5;
      @(negedge clk);
      start = 1'b1; base_addr = 16'h0010; length = 17'd1;
      k_tx = -1;
      for (k = 1; k <= 10 && k_tx < 0; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 1) begin
            check("rdreq_strobe", mem_read, 1'b1);
            check("rdreq_addr", mem_addr, 16'h0010);
            check("busy_after_start", busy, 1'b1);
         end
         if (tx_start) k_tx = k;
      end
      check("first_tx_latency", k_tx, 3);
      check("first_tx_data", tx_data, 8'h5A);
      wait_done(2000, ok);
      check("lat_done_seen", ok, 1'b1);
      check("addr_hold", mem_addr, 16'h0010);

      // Zero-length transfer: done exactly two cycles after start, nothing read.
      repeat (2) @(negedge clk);
      clear_logs();
      start = 1'b1; base_addr = 16'h0777; length = 17'd0;
      @(negedge clk);
      start = 1'b0;
      check("len0_c1_done", {busy, done}, 2'b10);
      @(negedge clk);
      check("len0_c2_done", {busy, done}, 2'b01);
      check("len0_words", words_sent, 17'd0);
      @(negedge clk);
      check("len0_c3_done", done, 1'b0);
      check("len0_no_reads", addr_log.size(), 0);
      check("len0_no_tx", tx_log.size(), 0);

      for (int i = 0; i < 6; i++) run_vec(tbl[i]);

      // A second start mid-transfer must not disturb the range in flight.
      clear_logs();
      busy_len = 5;
      do_start(16'h0040, 17'd2);
      repeat (5) @(negedge clk);
      start = 1'b1; base_addr = 16'h0200; length = 17'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done(2000, ok);
      check("intr_done_seen", ok, 1'b1);
      check("intr_words", words_sent, 17'd2);
      check("intr_nreads", addr_log.size(), 2);
      if (addr_log.size() == 2) begin
         check("intr_addr0", addr_log[0], 16'h0040);
         check("intr_addr1", addr_log[1], 16'h0041);
      end
      check("intr_nbytes", tx_log.size(), 4);
      if (tx_log.size() == 4) check("intr_byte3", tx_log[3], 8'hFF);
      repeat (3) @(negedge clk);
      check("intr_done_pulses", done_cnt, 1);

      // Reset held three cycles in the middle of a transfer.
      clear_logs();
      do_start(16'h0050, 17'd4);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("midrst");
      rst_n = 1'b1;
      done_cnt = 0;
      repeat (20) @(negedge clk);
      check("midrst_no_done", done_cnt, 0);
      check("midrst_idle", busy, 1'b0);
      run_vec(tbl[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_tx_streamer.md
Name: mem_tx_streamer

Overview:
Downstream stage of the data-memory/processor subsystem. After the processor signals end, this block streams a contiguous range of 16-bit data-memory words out through the UART transmitter. For each word it issues one memory read, waits the fixed read latency, and splits the word into bytes. Each byte is handed to the transmitter with a start/busy handshake. Replaces ad-hoc counter-driven transmit control in the top level.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory word width
BYTES_PER_WORD, 2, bytes sent per word (1 = low byte only, 2 = low then high)
MEM_LAT, 1, cycles from mem_read assertion to valid mem_rdata (1..3)
BUSY_TO, 8, max cycles to wait for tx_busy to rise after tx_start

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  transfer request; sampled only in IDLE
base_addr  in  ADDR_W  first word address; latched on accepted start
length  in  ADDR_W+1  word count, 0..65536; latched on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at transfer end
err  out  1  sticky handshake-timeout flag; cleared by next accepted start
words_sent  out  ADDR_W+1  words fully transmitted in current/last transfer
mem_read  out  1  memory read strobe
mem_addr  out  ADDR_W  memory address
mem_rdata  in  DATA_W  memory read data
tx_data  out  8  byte to transmitter
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  transmitter busy

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE. busy, done, err, mem_read, tx_start = 0. mem_addr, tx_data, words_sent = 0. Reset mid-transfer aborts immediately with no done pulse.
- States:
  - IDLE: on start=1, latch base_addr/length, clear err and words_sent, set busy. If length==0, go FINISH; otherwise go RD_REQ.
  - RD_REQ: mem_read=1 and mem_addr=cur_addr for exactly one cycle, then RD_WAIT.
  - RD_WAIT: count MEM_LAT cycles from the RD_REQ cycle. On the MEM_LAT-th edge, capture mem_rdata into the word register and set byte_idx=0. Go SEND.
  - SEND: tx_data = byte byte_idx (0 = bits[7:0], 1 = bits[15:8]). tx_start=1 for exactly one cycle. Go WAIT_HI.
  - WAIT_HI: wait for tx_busy=1, then go WAIT_LO. If BUSY_TO cycles elapse without tx_busy, set err=1 and go WAIT_LO anyway, so the transfer never deadlocks.
  - WAIT_LO: wait for tx_busy=0. Then:
    - if byte_idx < BYTES_PER_WORD-1: increment byte_idx, go SEND;
    - else: increment words_sent and cur_addr. If words_sent+1==length go FINISH, else go RD_REQ.
  - FINISH: done=1 for one cycle, busy=0, go IDLE.
- tx_data holds its value from SEND until the next SEND.
- mem_read is low in every state except RD_REQ. mem_addr holds its last value outside RD_REQ.
- cur_addr wraps modulo 2^ADDR_W (0xFFFF+1 = 0x0000). length=65536 sends the entire address space once.
- start while busy is ignored: no relatch, no effect on counters.
- If tx_busy is already high on entry to WAIT_HI, advance on that cycle.
- Minimum per-byte cost: 1 (SEND) + 1 (WAIT_HI) + 1 (WAIT_LO) cycles. Minimum per-word overhead: 1 + MEM_LAT cycles.
- Latency from accepted start to first tx_start: 2 + MEM_LAT cycles.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RD_REQ, RD_WAIT, SEND, WAIT_HI, WAIT_LO, FINISH);
  - ADDR_W/DATA_W defaults, shared with the memory and processor blocks;
  - the byte-select function.
- One natural sub-module: tx_handshake, which owns SEND/WAIT_HI/WAIT_LO, the BUSY_TO timer and err generation. It has a byte-in/valid/ack interface to the word sequencer.

Test Plan:
- Reset held 3 cycles mid-transfer, then released → all outputs 0, no done pulse, subsequent start works normally.
- length=0, start=1 → no mem_read, no tx_start, done pulse exactly 2 cycles after start, words_sent=0.
- base=0x0010, length=1, mem[0x0010]=0xA55A, model tx_busy high for 5 cycles after each tx_start → tx_data 0x5A then 0xA5, two tx_start pulses, done, words_sent=1.
- base=0xFFFF, length=3 → mem_addr sequence 0xFFFF, 0x0000, 0x0001; six bytes in low/high order; words_sent=3.
- start pulsed again during transfer with a different base_addr → ignored; original range is completed unchanged.
- tx_busy tied 0 → err=1 after BUSY_TO cycles per byte, transfer still completes with done; next start clears err.
